// File: rtl/muldiv_unit.sv
//==============================================================================
// Module      : muldiv_unit
// Description : Iterative MIPS multiply/divide unit with HI/LO registers.
//               The div0 flag port is present only with MULDIV_DIV0_FLAG_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
`ifdef MULDIV_DIV0_FLAG_EN
  output logic [WIDTH-1:0] lo,
  output logic             div0
`else
  output logic [WIDTH-1:0] lo
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      c_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      c_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] c_ONE2     = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg_lo;
  logic                 r_neg_hi;
  logic                 r_dz;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_a_raw;
  logic [2*WIDTH-1:0]   r_p;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_add;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  assign w_a_neg = ~op[0] & srcA[WIDTH-1];
  assign w_b_neg = ~op[0] & srcB[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~srcA + c_ONE) : srcA;
  assign w_b_mag = w_b_neg ? (~srcB + c_ONE) : srcB;

  // Multiply: r_p = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_add      = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_add, r_p[WIDTH-1:1]};

  // Divide: r_p = {partial remainder, dividend bits then quotient bits}, shifted left.
  assign w_rem_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_p[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_lo ? (~r_p + c_ONE2) : r_p;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_res_hi = r_a_raw;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_hi ? (~r_p[2*WIDTH-1:WIDTH] + c_ONE) : r_p[2*WIDTH-1:WIDTH];
        w_res_lo = r_neg_lo ? (~r_p[WIDTH-1:0] + c_ONE) : r_p[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      r_b      <= '0;
      r_a_raw  <= '0;
      r_p      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= op[1] & w_a_neg;
            r_dz     <= op[1] & (srcB == '0);
            r_a_raw  <= srcA;
            r_b      <= op[1] ? w_b_mag : w_a_mag;
            r_p      <= op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
          end else begin
            if (hiWrite) r_hi <= wrData;
            if (loWrite) r_lo <= wrData;
          end
        end
        S_RUN: begin
          r_p   <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_CNT_LAST) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

`ifdef MULDIV_DIV0_FLAG_EN
  logic r_div0;

  always_ff @(posedge clk) begin
    if (reset) r_div0 <= 1'b0;
    else       r_div0 <= (r_state == S_FINISH) && r_is_div && r_dz;
  end

  assign div0 = r_div0;
`else
  // No flag output; the zero-divisor result override above is shared by both builds.
`endif

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//==============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit against a cycle-count model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  srcA = '0;
  logic [W-1:0]  srcB = '0;
  logic          hiWrite = 1'b0;
  logic          loWrite = 1'b0;
  logic [W-1:0]  wrData = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic          div0;
`endif

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .srcA    (srcA),
    .srcB    (srcB),
    .hiWrite (hiWrite),
    .loWrite (loWrite),
    .wrData  (wrData),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
`ifdef MULDIV_DIV0_FLAG_EN
    .lo      (lo),
    .div0    (div0)
`else
    .lo      (lo)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from the instruction definitions.
  function automatic void model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl, output bit dz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (b == '0) begin
          dz = 1'b1; rl = '1; rh = a;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          rl = q[31:0]; rh = r[31:0];
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endfunction

  // Model: an accepted start schedules its result W+1 edges later.
  int           m_cnt = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_rh = '0, m_rl = '0;
  bit           m_done = 1'b0, m_div0 = 1'b0, m_dz = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    m_div0 = 1'b0;
    if (reset) begin
      m_cnt = 0; m_hi = '0; m_lo = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_hi = m_rh; m_lo = m_rl; m_done = 1'b1; m_div0 = m_dz;
      end
    end else if (start) begin
      model_op(op, srcA, srcB, m_rh, m_rl, m_dz);
      m_cnt = W + 1;
    end else begin
      if (hiWrite) m_hi = wrData;
      if (loWrite) m_lo = wrData;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'b0, busy}, {63'b0, (m_cnt > 0)});
      chk("done", {63'b0, done}, {63'b0, m_done});
      chk("hi", {32'b0, hi}, {32'b0, m_hi});
      chk("lo", {32'b0, lo}, {32'b0, m_lo});
`ifdef MULDIV_DIV0_FLAG_EN
      chk("div0", {63'b0, div0}, {63'b0, m_div0});
`endif
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int bcyc);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0;
    while (busy === 1'b1 && bcyc < 100) begin
      bcyc++;
      @(negedge clk);
    end
    if (bcyc >= 100) chk("timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int  bc;
    bit  saw_done;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, bc);
    chk("mult_busy_cycles", 64'(bc), 64'd33);
    chk("mult_done", {63'b0, done}, 64'd1);
    chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    chk("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, bc);
    chk("div_neg_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(2'b11, 32'd100, 32'd7, bc);
    chk("divu_res", {hi, lo}, {32'd2, 32'd14});

    run_op(2'b11, 32'h0000_1234, 32'h0, bc);
    chk("divu0_busy_cycles", 64'(bc), 64'd33);
    chk("divu0_res", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
`ifdef MULDIV_DIV0_FLAG_EN
    chk("divu0_flag", {63'b0, div0}, 64'd1);
`endif

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    chk("div_ovf_res", {hi, lo}, 64'h0000_0000_8000_0000);

    // start with loWrite in the same cycle: the strobe is dropped.
    @(negedge clk);
    loWrite = 1'b1; wrData = 32'hDEAD_BEEF;
    start = 1'b1; op = 2'b01; srcA = 32'd2; srcB = 32'd3;
    @(negedge clk);
    loWrite = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    hiWrite = 1'b1; start = 1'b1; op = 2'b00; srcA = 32'd9; srcB = 32'd9; wrData = 32'h1111_1111;
    @(negedge clk);
    hiWrite = 1'b0; start = 1'b0;
    bc = 0;
    while (done !== 1'b1 && bc < 100) begin bc++; @(negedge clk); end
    chk("strobe_drop_res", {hi, lo}, {32'd0, 32'd6});

    @(negedge clk);
    loWrite = 1'b1; wrData = 32'hA5A5_A5A5;
    @(negedge clk);
    loWrite = 1'b0;
    chk("mtlo", {32'b0, lo}, {32'b0, 32'hA5A5_A5A5});

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; op = 2'b00; srcA = 32'd1234; srcB = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_state", {30'b0, busy, done, hi}, 64'd0);
    chk("midrst_lo", {32'b0, lo}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("midrst_no_done", {63'b0, saw_done}, 64'd0);

    run_op(2'b00, 32'd6, 32'd7, bc);
    chk("mult_after_rst", {hi, lo}, {32'd0, 32'd42});

    // Randomized traffic: starts (incl. back-to-back and while busy), strobes, rare resets.
    repeat (4000) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) == 0);
      op      = 2'($urandom_range(0, 3));
      srcA    = pick_operand();
      srcB    = pick_operand();
      hiWrite = ($urandom_range(0, 3) == 0);
      loWrite = ($urandom_range(0, 3) == 0);
      wrData  = $urandom();
      reset   = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
